// File: rtl/rj_loader_if.sv
// Rj loader bus: serial framed input side and Rj memory write-port side.
interface rj_loader_if;
  localparam int unsigned W_WORD = 16;
  localparam int unsigned W_ADDR = 4;

  logic              start;
  logic              frame;
  logic              sdata;
  logic              write_enable;
  logic [W_ADDR-1:0] rjwrite;
  logic [W_WORD-1:0] in_data;
  logic              busy;
  logic              rj_done;
  logic              sync_err;

  modport master (
    output start, frame, sdata,
    input  write_enable, rjwrite, in_data, busy, rj_done, sync_err
  );

  modport slave (
    input  start, frame, sdata,
    output write_enable, rjwrite, in_data, busy, rj_done, sync_err
  );
endinterface

// File: rtl/rj_loader.sv
// Deserializes 16 framed MSB-first words and writes them to the 16-entry Rj memory.
module rj_loader (
  input  logic         Sclk,
  input  logic         Reset_n,
  rj_loader_if.slave   bus
);
  localparam int unsigned W_WORD = 16;
  localparam int unsigned W_ADDR = 4;
  localparam int unsigned W_BCNT = 4;
  localparam int unsigned W_WCNT = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    SHIFT      = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [W_WORD-1:0]   sh_q, sh_d;
  logic [W_BCNT-1:0]   bcnt_q, bcnt_d;
  logic [W_WCNT-1:0]   wcnt_q, wcnt_d;
  logic                we_q, we_d;
  logic [W_ADDR-1:0]   rjwrite_q, rjwrite_d;
  logic [W_WORD-1:0]   in_data_q, in_data_d;
  logic                busy_q, busy_d;
  logic                rj_done_q, rj_done_d;
  logic                sync_err_q, sync_err_d;
  logic                busy_now_c, busy_next_c;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    we_d       = 1'b0;
    rjwrite_d  = rjwrite_q;
    in_data_d  = in_data_q;
    sync_err_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          wcnt_d  = '0;
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (bus.frame) begin
          sh_d    = {15'b0, bus.sdata};
          bcnt_d  = W_BCNT'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.frame) begin
          // Frame mid-word: drop the partial word and start capturing afresh.
          sync_err_d = 1'b1;
          sh_d       = {15'b0, bus.sdata};
          bcnt_d     = W_BCNT'(1);
        end else begin
          sh_d   = {sh_q[W_WORD-2:0], bus.sdata};
          bcnt_d = bcnt_q + W_BCNT'(1);
          if (bcnt_q == W_BCNT'(15)) begin
            we_d      = 1'b1;
            in_data_d = {sh_q[W_WORD-2:0], bus.sdata};
            rjwrite_d = wcnt_q[W_ADDR-1:0];
            wcnt_d    = wcnt_q + W_WCNT'(1);
            state_d   = (wcnt_q == W_WCNT'(15)) ? DONE : WAIT_FRAME;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // busy stays up through the final write cycle; rj_done rises one cycle after it.
    busy_now_c  = (state_q == WAIT_FRAME) || (state_q == SHIFT);
    busy_next_c = (state_d == WAIT_FRAME) || (state_d == SHIFT);
    busy_d      = busy_now_c || busy_next_c;
    rj_done_d   = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      we_q       <= 1'b0;
      rjwrite_q  <= '0;
      in_data_q  <= '0;
      busy_q     <= 1'b0;
      rj_done_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      we_q       <= we_d;
      rjwrite_q  <= rjwrite_d;
      in_data_q  <= in_data_d;
      busy_q     <= busy_d;
      rj_done_q  <= rj_done_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.write_enable = we_q;
  assign bus.rjwrite      = rjwrite_q;
  assign bus.in_data      = in_data_q;
  assign bus.busy         = busy_q;
  assign bus.rj_done      = rj_done_q;
  assign bus.sync_err     = sync_err_q;

endmodule

// File: tb/tb_rj_loader.sv
// Randomized bench for rj_loader against a transaction-level expected-write model.
module tb_rj_loader;
  logic Sclk;
  logic Reset_n;

  rj_loader_if bus ();

  rj_loader u_dut (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  int checks = 0;
  int errors = 0;

  // Model: which words should land where, in order.
  logic [19:0] exp_q[$];
  logic [15:0] exp_mem[16];
  logic [15:0] tb_mem[16];
  bit          model_loading = 1'b0;
  int          model_wcnt    = 0;
  int          sync_cnt      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic f, input logic d, input logic s);
    bus.frame = f;
    bus.sdata = d;
    bus.start = s;
    @(posedge Sclk);
    #1;
  endtask

  task automatic do_start(input logic f);
    model_loading = 1'b1;
    model_wcnt    = 0;
    cyc(f, 1'($urandom), 1'b1);
  endtask

  task automatic expect_word(input logic [15:0] w);
    if (model_loading) begin
      exp_q.push_back({4'(model_wcnt), w});
      exp_mem[model_wcnt] = w;
      model_wcnt++;
      if (model_wcnt == 16) model_loading = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) cyc(i == 0, w[15-i], 1'b0);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap, input int start_bit, input bit chk_busy);
    for (int g = 0; g < gap; g++) cyc(1'b0, 1'($urandom), 1'b0);
    expect_word(w);
    for (int i = 0; i < 16; i++) begin
      cyc(i == 0, w[15-i], i == start_bit);
      if (chk_busy) begin
        chk("busy_run", bus.busy, 1);
        chk("done_run", bus.rj_done, 0);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},   bus.write_enable, 0);
    chk({tag, "_addr"}, bus.rjwrite, 0);
    chk({tag, "_data"}, bus.in_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.rj_done, 0);
    chk({tag, "_serr"}, bus.sync_err, 0);
  endtask

  // Write-port monitor acting as the Rj memory.
  always @(negedge Sclk) begin
    if (Reset_n) begin
      if (bus.write_enable) begin
        if (exp_q.size() == 0) begin
          chk("unexp_we", bus.write_enable, 0);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("we_addr", bus.rjwrite, e[19:16]);
          chk("we_data", bus.in_data, e[15:0]);
        end
        tb_mem[bus.rjwrite] = bus.in_data;
      end
      if (bus.sync_err) begin
        sync_cnt++;
        chk("serr_we_excl", bus.write_enable, 0);
      end
    end
  end

  initial begin
    int base;
    logic [15:0] w;
    bus.start = 1'b0;
    bus.frame = 1'b0;
    bus.sdata = 1'b0;
    Reset_n   = 1'b0;
    repeat (3) @(posedge Sclk);
    #1;
    chk_zero("rst_init");
    Reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Single word
    do_start(1'b0);
    send_word(16'hA5C3, 2, -1, 1'b1);
    chk("single_we", bus.write_enable, 1);
    chk("single_addr", bus.rjwrite, 0);
    chk("single_data", bus.in_data, 16'hA5C3);
    cyc(1'b0, 1'b0, 1'b0);
    chk("single_we_pulse", bus.write_enable, 0);
    chk("single_hold", bus.in_data, 16'hA5C3);

    // Reset mid-word abandons the load
    send_bits(16'h7E81, 7);
    #2 Reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_loading = 1'b0;
    model_wcnt    = 0;
    exp_q.delete();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    Reset_n = 1'b1;
    send_word(16'h5555, 1, -1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("nostart_busy", bus.busy, 0);

    // Full back-to-back load
    for (int i = 0; i < 16; i++) tb_mem[i] = 16'h0;
    do_start(1'b0);
    for (int k = 1; k <= 16; k++) send_word(16'(k), 0, -1, 1'b0);
    chk("last_we", bus.write_enable, 1);
    chk("last_addr", bus.rjwrite, 15);
    chk("done_lag", bus.rj_done, 0);
    chk("busy_lag", bus.busy, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_rise", bus.rj_done, 1);
    chk("busy_fall", bus.busy, 0);
    for (int i = 0; i < 16; i++) chk("mem_b2b", tb_mem[i], exp_mem[i]);

    // DONE ignores frame/sdata
    repeat (30) cyc(1'($urandom), 1'($urandom), 1'b0);
    chk("done_hold", bus.rj_done, 1);

    // Restart with simultaneous frame (frame ignored), then resync
    for (int i = 0; i < 16; i++) tb_mem[i] = 16'h0;
    do_start(1'b1);
    chk("restart_done_clr", bus.rj_done, 0);
    chk("restart_busy", bus.busy, 1);
    send_word(16'h1234, 1, -1, 1'b0);
    chk("restart_addr", bus.rjwrite, 0);
    base = sync_cnt;
    send_bits(16'hC3C3, 8);
    send_word(16'hBEEF, 0, -1, 1'b0);
    chk("resync_cnt", sync_cnt, base + 1);
    chk("resync_addr", bus.rjwrite, 1);
    chk("resync_data", bus.in_data, 16'hBEEF);

    // Random gaps, random data, start pulses mid-word
    for (int k = 0; k < 14; k++) begin
      w = 16'($urandom);
      send_word(w, $urandom_range(0, 4), $urandom_range(1, 15), 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("rand_done", bus.rj_done, 1);
    chk("rand_busy", bus.busy, 0);
    for (int i = 0; i < 16; i++) chk("mem_rand", tb_mem[i], exp_mem[i]);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rj_loader.md
# rj_loader

Serial-to-parallel loader that fills the 16-entry Rj coefficient memory of the MSDAP during initialization. It deserializes 16 framed, MSB-first 16-bit words from a one-bit serial input and issues one registered write per word, producing `write_enable`, `rjwrite` and `in_data` for the Rj memory's write port. It sits between the serial input front end and the Rj memory. It signals completion so the controller can move on to coefficient loading.

## Interface
- No parameters. Word width is fixed at 16 bits and word count at 16.
- `Sclk  input  1` — system clock; all state updates on its rising edge.
- `Reset_n  input  1` — asynchronous, active-low reset.
- `start  input  1` — one-cycle request to begin a 16-word load; honoured only in IDLE or DONE.
- `frame  input  1` — word-start strobe; high in the cycle carrying bit 15 (MSB) of a word.
- `sdata  input  1` — serial data bit, sampled every `Sclk` edge while loading.
- `write_enable  output  1` — one-cycle write strobe to the Rj memory.
- `rjwrite  output  4` — Rj memory write address, 0..15.
- `in_data  output  16` — assembled word to be written.
- `busy  output  1` — high in WAIT_FRAME and SHIFT.
- `rj_done  output  1` — high after all 16 words are written; held until the next `start` or reset.
- `sync_err  output  1` — one-cycle pulse when `frame` arrives mid-word.

## Operation
- States: IDLE, WAIT_FRAME, SHIFT, DONE. A 2-bit encoding is sufficient.
- Internal registers: 16-bit shift register `sh`, 4-bit bit counter `bcnt`, 5-bit word counter `wcnt`.
- **IDLE**
  - On `start`: clear `wcnt` and `rj_done`, then go to WAIT_FRAME.
- **WAIT_FRAME**
  - When `frame` = 1: `sh` <= {15'b0, `sdata`}, `bcnt` <= 1, go to SHIFT.
  - Otherwise: hold.
- **SHIFT**, `frame` = 0:
  - Each cycle, `sh` <= {`sh[14:0]`, `sdata`} and `bcnt` increments.
  - On the cycle with `bcnt` = 15 (the 16th bit):
    - `in_data` <= {`sh[14:0]`, `sdata`}.
    - `rjwrite` <= `wcnt[3:0]`.
    - `write_enable` <= 1 for exactly one cycle.
    - `wcnt` increments.
    - Next state is DONE if `wcnt` was 15, otherwise WAIT_FRAME.
- **SHIFT**, `frame` = 1 (resynchronization):
  - Discard the partial word and pulse `sync_err`.
  - Restart capture: `sh` <= {15'b0, `sdata`}, `bcnt` <= 1.
  - `wcnt` is unchanged and no write is issued.
- **DONE**
  - `rj_done` = 1; `frame` and `sdata` are ignored.
  - On `start`: behave as in IDLE (clear `wcnt` and `rj_done`, go to WAIT_FRAME).
- `start` in WAIT_FRAME or SHIFT is ignored.
- `in_data` and `rjwrite` hold their last written values between writes.
- `write_enable` is 0 in every cycle other than the write pulse.

## Timing
- Reset values: all outputs 0, state IDLE, `sh`, `bcnt` and `wcnt` all 0. Reset applies immediately and asynchronously.
- Reset mid-word or mid-load: the partial load is abandoned. After reset release, a new `start` is required.
- Latency: `write_enable`, `in_data` and `rjwrite` are all registered and are valid in the cycle after the 16th bit is sampled.
  - The Rj memory captures the word on the following `Sclk` edge.
- Back-to-back words: `frame` may be high in the same cycle that `write_enable` is high. The MSB of the next word is captured with no gap.
- Minimum load time: 16 × 16 = 256 cycles from the first `frame` to the last `write_enable`.
- `rj_done` rises in the cycle after the 16th `write_enable` (state DONE).
- `busy` falls in that same cycle.
- Simultaneous `start` and `frame`:
  - In IDLE or DONE, `frame` is ignored; capture begins at the next `frame`.
  - In WAIT_FRAME, `start` is ignored and `frame` is honoured.
- `sync_err` and `write_enable` are never high in the same cycle.

## Test plan
- **Reset values:** hold `Reset_n` = 0 mid-SHIFT. All outputs must read 0. Release, then `start`, then 16 words → writes must begin at `rjwrite` = 0.
- **Single word:** `start`, then `frame` with bits 0xA5C3 MSB first → exactly one `write_enable` pulse, 16 cycles after `frame`, with `in_data` = 0xA5C3 and `rjwrite` = 0. `busy` = 1 and `rj_done` = 0 throughout.
- **Full back-to-back load:** 16 words 0x0001, 0x0002, … 0x0010 with `frame` every 16 cycles.
  - 16 pulses, with `rjwrite` = 0..15 and matching data.
  - `rj_done` = 1 at cycle 257 after the first `frame`.
  - A memory model must read back all 16 words.
- **Resync:** `frame` at bit 7 of a word → `sync_err` pulses once, no write occurs, `wcnt` is unchanged. The next full word 0xBEEF is written at the same address.
- **Idle gaps and ignored `start`:** random gaps between words, plus `start` pulsed during SHIFT → no effect. Addresses stay contiguous and the data is correct.
- **Restart after DONE:** `frame`/`sdata` toggling while in DONE → no writes. A second `start` clears `rj_done`, and the next word is written to `rjwrite` = 0.
